// File: rtl/design_1_ma_accum.sv
`default_nettype none
// ============================================================================
// Module      : design_1_ma_accum
// Description : Group accumulator for the MAC result stream. Sums up to
//               BEATS signed beats (fewer when s_last closes a group early)
//               into a wider wrapping accumulator. Each group total is
//               presented on a registered valid/ready port together with
//               its beat count and a sticky signed-overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module design_1_ma_accum #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int BEATS      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        s_data,
    input  logic                         s_valid,
    input  logic                         s_last,
    output logic                         s_ready,
    output logic [ACC_WIDTH-1:0]         m_data,
    output logic [$clog2(BEATS+1)-1:0]   m_count,
    output logic                         m_ovf,
    output logic                         m_valid,
    input  logic                         m_ready
);

    localparam int                CNT_W     = $clog2(BEATS + 1);
    localparam logic [CNT_W-1:0]  c_LAST_IDX = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  c_ONE      = CNT_W'(1);

    logic [ACC_WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_ovf_acc;
    logic [ACC_WIDTH-1:0] r_m_data;
    logic [CNT_W-1:0]     r_m_count;
    logic                 r_m_ovf;
    logic                 r_m_valid;

    logic [ACC_WIDTH-1:0] w_ext;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_ovf;
    logic                 w_closing;
    logic                 w_accept;

    // Sign-extend the incoming beat and form the wrapping running sum.
    // A freshly cleared accumulator is zero, so the first beat of a group
    // can never raise overflow.
    always_comb begin
        w_ext     = ACC_WIDTH'($signed(s_data));
        w_sum     = r_acc + w_ext;
        w_ovf     = (r_acc[ACC_WIDTH-1] == w_ext[ACC_WIDTH-1]) &&
                    (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
        // s_last only counts when the beat is actually presented.
        w_closing = s_valid && ((r_cnt == c_LAST_IDX) || s_last);
        // Only a closing beat needs the output register; it stalls while
        // the register holds a group that is not draining this cycle.
        s_ready   = reset && !(w_closing && r_m_valid && !m_ready);
        w_accept  = s_valid && s_ready;
    end

    // Accumulate open-group beats and hand closed groups to the output
    // register; a drain and a new close on the same edge keep m_valid high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf_acc <= 1'b0;
            r_m_data  <= '0;
            r_m_count <= '0;
            r_m_ovf   <= 1'b0;
            r_m_valid <= 1'b0;
        end else begin
            if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end
            if (w_accept) begin
                if (w_closing) begin
                    r_m_data  <= w_sum;
                    r_m_count <= r_cnt + c_ONE;
                    r_m_ovf   <= r_ovf_acc | w_ovf;
                    r_m_valid <= 1'b1;
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    r_ovf_acc <= 1'b0;
                end else begin
                    r_acc     <= w_sum;
                    r_cnt     <= r_cnt + c_ONE;
                    r_ovf_acc <= r_ovf_acc | w_ovf;
                end
            end
        end
    end

    assign m_data  = r_m_data;
    assign m_count = r_m_count;
    assign m_ovf   = r_m_ovf;
    assign m_valid = r_m_valid;

endmodule
`default_nettype wire

// File: tb/tb_design_1_ma_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_design_1_ma_accum
// Description : Scoreboard bench for design_1_ma_accum. Two instances share
//               one input stream: a 32-bit accumulator and a 17-bit one that
//               exercises overflow. Closed groups are modelled with plain
//               integer arithmetic and queued; a monitor compares each
//               presented group against the queue head.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_design_1_ma_accum;

    localparam int c_BEATS = 4;

    logic        clk;
    logic        reset;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        m_ready;

    logic        s_ready_a, m_ovf_a, m_valid_a;
    logic [31:0] m_data_a;
    logic [2:0]  m_count_a;
    logic        s_ready_b, m_ovf_b, m_valid_b;
    logic [16:0] m_data_b;
    logic [2:0]  m_count_b;

    design_1_ma_accum #(.DATA_WIDTH(16), .ACC_WIDTH(32), .BEATS(c_BEATS)) u_dut_a (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready_a), .m_data(m_data_a), .m_count(m_count_a), .m_ovf(m_ovf_a),
        .m_valid(m_valid_a), .m_ready(m_ready)
    );

    design_1_ma_accum #(.DATA_WIDTH(16), .ACC_WIDTH(17), .BEATS(c_BEATS)) u_dut_b (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready_b), .m_data(m_data_b), .m_count(m_count_b), .m_ovf(m_ovf_b),
        .m_valid(m_valid_b), .m_ready(m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d32;
        logic [16:0] d17;
        int          cnt;
        bit          o32;
        bit          o17;
    } exp_t;

    exp_t   q[$];
    int     grp[$];
    int     n_total = 0;
    int     n_pass  = 0;
    int     mode    = 1;   // 0: m_ready low, 1: m_ready high, 2: random
    bit     r_closing, r_occ, r_exp_sr;
    exp_t   r_e, r_front;

    task automatic check(input string name, input longint act, input longint req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    endtask

    // Exact-integer group sum: any partial sum outside the signed range of
    // the accumulator width flags overflow, and the total wraps to that width.
    function automatic void group_sum(input int vals[$], input int w,
                                      output longint res, output bit ovf);
        longint acc, exact, lo, hi, m;
        m   = longint'(1) <<< w;
        hi  = (longint'(1) <<< (w - 1)) - 1;
        lo  = -(longint'(1) <<< (w - 1));
        acc = 0;
        ovf = 0;
        foreach (vals[i]) begin
            exact = acc + longint'(vals[i]);
            if (exact > hi || exact < lo) ovf = 1;
            acc = exact % m;
            if (acc > hi) acc -= m;
            if (acc < lo) acc += m;
        end
        res = acc & (m - 1);
    endfunction

    // Scoreboard and monitor, evaluated mid-cycle when everything is stable.
    always @(negedge clk) begin
        if (!reset) begin
            check("s_ready_in_reset_a", s_ready_a, 0);
            check("s_ready_in_reset_b", s_ready_b, 0);
            q.delete();
            grp.delete();
        end else begin
            r_closing = s_valid && ((grp.size() == c_BEATS - 1) || s_last);
            r_occ     = (q.size() > 0);
            r_exp_sr  = !(r_closing && r_occ && !m_ready);
            check("s_ready_a", s_ready_a, r_exp_sr);
            check("s_ready_b", s_ready_b, r_exp_sr);
            check("m_valid_a", m_valid_a, r_occ);
            check("m_valid_b", m_valid_b, r_occ);
            if (m_valid_a && r_occ) begin
                r_front = q[0];
                check("m_data_a",  m_data_a,  r_front.d32);
                check("m_count_a", m_count_a, r_front.cnt);
                check("m_ovf_a",   m_ovf_a,   r_front.o32);
                check("m_data_b",  m_data_b,  r_front.d17);
                check("m_count_b", m_count_b, r_front.cnt);
                check("m_ovf_b",   m_ovf_b,   r_front.o17);
                if (m_ready) void'(q.pop_front());
            end
            if (s_valid && s_ready_a) begin
                longint res;
                bit     ov;
                grp.push_back(int'($signed(s_data)));
                if (r_closing) begin
                    group_sum(grp, 32, res, ov);
                    r_e.d32 = res[31:0];
                    r_e.o32 = ov;
                    group_sum(grp, 17, res, ov);
                    r_e.d17 = res[16:0];
                    r_e.o17 = ov;
                    r_e.cnt = grp.size();
                    q.push_back(r_e);
                    grp.delete();
                end
            end
        end
    end

    // Downstream ready generator.
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one beat until accepted; idle inputs carry junk s_last/s_data.
    task automatic send(input logic [15:0] d, input bit last);
        int n;
        bit took;
        n = 0;
        took = 0;
        s_data  = d;
        s_valid = 1'b1;
        s_last  = last;
        while (!took && n < 200) begin
            @(negedge clk);
            took = s_ready_a;
            @(posedge clk);
            #1;
            n++;
        end
        if (!took) begin
            n_total++;
            $display("FAIL send_timeout actual=stalled required=accepted at %0t", $time);
        end
        s_valid = 1'b0;
        s_last  = 1'($urandom_range(0, 1));
        s_data  = 16'($urandom);
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        s_valid = 1'b0;
        idle(1);
        reset   = 1'b1;
    endtask

    initial begin
        logic [15:0] d;
        reset   = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = '0;
        idle(3);
        check("m_valid_after_reset", m_valid_a, 0);
        check("m_data_after_reset",  m_data_a, 0);
        check("m_count_after_reset", m_count_a, 0);
        reset = 1'b1;

        mode = 1;
        send(16'd1, 0); send(16'd2, 0); send(16'd3, 0); send(16'd4, 0);
        send(-16'sd5, 0); send(16'd3, 0); send(-16'sd1, 0); send(-16'sd1, 0);
        send(16'd7, 0); send(16'd8, 1);
        send(16'd9, 1);
        repeat (4) send(16'h7FFF, 0);
        idle(3);

        // Backpressure: fourth beat of the second group must stall.
        mode = 0;
        idle(1);
        repeat (4) send(16'd1, 0);
        repeat (3) send(16'd2, 0);
        fork
            send(16'd2, 0);
            begin idle(6); mode = 1; end
        join
        idle(3);

        // Reset in the middle of a group.
        send(16'd5, 0); send(16'd5, 0);
        do_reset();
        repeat (4) send(16'd1, 0);
        idle(3);

        // Randomized traffic with random backpressure and gaps.
        mode = 2;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 5))
                0:       d = 16'h7FFF;
                1:       d = 16'h8000;
                default: d = 16'($urandom);
            endcase
            send(d, ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            if (i == 300) do_reset();
        end
        if (grp.size() != 0) send(16'd0, 1);

        mode = 1;
        idle(10);
        check("queue_drained", q.size(), 0);
        check("group_closed", grp.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
